// File: rtl/hyperbus_read_packer_if.sv
// Read-packer bus bundle: CDC FIFO pop side (in_*) and packed beat side (valid/data/strb/last/ready).
// master = the packer itself, slave = the environment driving words and accepting beats.
interface hyperbus_read_packer_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) ();
    logic               in_valid_i;
    logic [IN_W-1:0]    in_data_i;
    logic               in_ready_o;
    logic               valid_o;
    logic [OUT_W-1:0]   data_o;
    logic [OUT_W/8-1:0] strb_o;
    logic               last_o;
    logic               ready_i;

    modport master (
        input  in_valid_i, in_data_i, ready_i,
        output in_ready_o, valid_o, data_o, strb_o, last_o
    );

    modport slave (
        output in_valid_i, in_data_i, ready_i,
        input  in_ready_o, valid_o, data_o, strb_o, last_o
    );
endinterface

// File: rtl/hyperbus_read_packer.sv
// Packs a burst of IN_W read words little-endian into OUT_W beats with strobes and last.
// Optional RWDS-stall watchdog enabled by defining HYPERBUS_READ_TIMEOUT_EN.
module hyperbus_read_packer #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                 clk0,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
    hyperbus_read_packer_if.master bus,
    output logic                 busy_o,
    output logic                 drop_o,
    output logic                 timeout_o
);
    localparam int unsigned RATIO   = OUT_W / IN_W;
    localparam int unsigned STRB_W  = OUT_W / 8;
    localparam int unsigned WSTRB_W = IN_W / 8;
    localparam int unsigned SLOT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [STRB_W-1:0]  acc_strb_q, acc_strb_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [STRB_W-1:0]  strb_q, strb_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               drop_q, drop_d;

    logic               in_ready;
    logic               accept;
    logic               out_stall;
    logic               exiting;
    logic [OUT_W-1:0]   acc_w;
    logic [STRB_W-1:0]  acc_strb_w;

`ifdef HYPERBUS_READ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = ^timeout_cfg_i;
`endif

    // Accumulator with the incoming word merged into the current slot.
    always_comb begin
        acc_w      = acc_q;
        acc_strb_w = acc_strb_q;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                acc_w[k*IN_W +: IN_W]            = bus.in_data_i;
                acc_strb_w[k*WSTRB_W +: WSTRB_W] = '1;
            end
        end
    end

    always_comb begin
        out_stall = valid_q && !bus.ready_i;
        exiting   = valid_q && last_q;
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else begin
            // Closing the pop during the final beat keeps a timed-out burst from eating the next burst's words.
            in_ready = !out_stall && !exiting && (remaining_q != '0);
        end
        accept = bus.in_valid_i && in_ready;

        state_d     = state_q;
        remaining_d = remaining_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        acc_strb_d  = acc_strb_q;
        data_d      = data_q;
        strb_d      = strb_q;
        last_d      = last_q;
        valid_d     = out_stall;
        drop_d      = 1'b0;
`ifdef HYPERBUS_READ_TIMEOUT_EN
        wdog_d      = wdog_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                drop_d = accept;
`ifdef HYPERBUS_READ_TIMEOUT_EN
                wdog_d = '0;
`endif
                if (start_i && (len_i != '0) && !valid_q) begin
                    state_d     = COLLECT;
                    remaining_d = len_i;
                    slot_d      = '0;
                    acc_d       = '0;
                    acc_strb_d  = '0;
                end
            end
            COLLECT: begin
                if (exiting) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if ((slot_q == SLOT_W'(RATIO - 1)) || (remaining_q == LEN_W'(1))) begin
                        valid_d    = 1'b1;
                        data_d     = acc_w;
                        strb_d     = acc_strb_w;
                        last_d     = (remaining_q == LEN_W'(1));
                        acc_d      = '0;
                        acc_strb_d = '0;
                        slot_d     = '0;
                    end else begin
                        acc_d      = acc_w;
                        acc_strb_d = acc_strb_w;
                        slot_d     = slot_q + SLOT_W'(1);
                    end
                end
`ifdef HYPERBUS_READ_TIMEOUT_EN
                if (accept) begin
                    wdog_d = '0;
                end else if (!out_stall && !exiting && (timeout_cfg_i != '0)) begin
                    if ((wdog_q + TIMEOUT_W'(1)) == timeout_cfg_i) begin
                        valid_d    = 1'b1;
                        data_d     = acc_q;
                        strb_d     = acc_strb_q;
                        last_d     = 1'b1;
                        timeout_d  = 1'b1;
                        acc_d      = '0;
                        acc_strb_d = '0;
                        slot_d     = '0;
                        wdog_d     = '0;
                    end else begin
                        wdog_d = wdog_q + TIMEOUT_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            slot_q      <= '0;
            acc_q       <= '0;
            acc_strb_q  <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            drop_q      <= 1'b0;
`ifdef HYPERBUS_READ_TIMEOUT_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            acc_strb_q  <= acc_strb_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
`ifdef HYPERBUS_READ_TIMEOUT_EN
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.in_ready_o = in_ready;
    assign bus.valid_o    = valid_q;
    assign bus.data_o     = data_q;
    assign bus.strb_o     = strb_q;
    assign bus.last_o     = last_q;
    assign busy_o         = (state_q != IDLE);
    assign drop_o         = drop_q;
`ifdef HYPERBUS_READ_TIMEOUT_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif
endmodule
